// File: rtl/psum_sram_arbiter.sv
// rtl/psum_sram_arbiter.sv - PSUM SRAM arbiter: MAC priority, SFU/host round-robin, SFU lock
// Optional: PSUM_ARB_STATS_EN adds saturating SFU/host wait-cycle counters.
module psum_sram_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 128,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mac_req,
    input  logic [ADDR_W-1:0] mac_addr,
    input  logic [DATA_W-1:0] mac_wdata,
    input  logic              sfu_req,
    input  logic              sfu_we,
    input  logic              sfu_lock,
    input  logic [ADDR_W-1:0] sfu_addr,
    input  logic [DATA_W-1:0] sfu_wdata,
    output logic              sfu_gnt,
    output logic              sfu_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              lock_err,
`ifdef PSUM_ARB_STATS_EN
    output logic [15:0]       stat_sfu_wait,
    output logic [15:0]       stat_host_wait,
`endif
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    typedef enum logic {ARB, LOCKED} state_t;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    state_t            state, state_nxt;
    logic              rr_host;
    logic              relock_block;
    logic [CNT_W-1:0]  lock_cnt;
    logic              sfu_rd_p, host_rd_p;
    logic [DATA_W-1:0] rdata_q;

    always_comb begin
        sfu_gnt   = 1'b0;
        host_gnt  = 1'b0;
        lock_err  = 1'b0;
        state_nxt = state;
        if (state == ARB) begin
            if (!mac_req) begin
                if (sfu_req && host_req) begin
                    sfu_gnt  = !rr_host;
                    host_gnt = rr_host;
                end else begin
                    sfu_gnt  = sfu_req;
                    host_gnt = host_req;
                end
            end
            if (sfu_gnt && sfu_lock && !relock_block)
                state_nxt = LOCKED;
        end else begin
            sfu_gnt = sfu_req && !mac_req;
            if (!sfu_lock) begin
                state_nxt = ARB;
            end else if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
                // last allowed locked cycle: force the port back to arbitration
                state_nxt = ARB;
                lock_err  = 1'b1;
            end
        end
        if (!reset) begin
            sfu_gnt  = 1'b0;
            host_gnt = 1'b0;
            lock_err = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ARB;
            rr_host      <= 1'b0;
            relock_block <= 1'b0;
            lock_cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (state == LOCKED && state_nxt == LOCKED)
                lock_cnt <= lock_cnt + 1'b1;
            else
                lock_cnt <= '0;
            if (lock_err || sfu_gnt)
                rr_host <= 1'b1;
            else if (host_gnt)
                rr_host <= 1'b0;
            // after a forced release SFU must drop sfu_lock before it can relock
            if (lock_err)
                relock_block <= 1'b1;
            else if (!sfu_lock)
                relock_block <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sram_cen <= 1'b1;
            sram_wen <= 1'b1;
            sram_a   <= '0;
            sram_d   <= '0;
        end else if (mac_req) begin
            sram_cen <= 1'b0;
            sram_wen <= 1'b0;
            sram_a   <= mac_addr;
            sram_d   <= mac_wdata;
        end else if (sfu_gnt) begin
            sram_cen <= 1'b0;
            sram_wen <= !sfu_we;
            sram_a   <= sfu_addr;
            if (sfu_we)
                sram_d <= sfu_wdata;
        end else if (host_gnt) begin
            sram_cen <= 1'b0;
            sram_wen <= !host_we;
            sram_a   <= host_addr;
            if (host_we)
                sram_d <= host_wdata;
        end else begin
            sram_cen <= 1'b1;
            sram_wen <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sfu_rd_p    <= 1'b0;
            host_rd_p   <= 1'b0;
            sfu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            rdata_q     <= '0;
        end else begin
            sfu_rd_p    <= sfu_gnt && !sfu_we;
            host_rd_p   <= host_gnt && !host_we;
            sfu_rvalid  <= sfu_rd_p;
            host_rvalid <= host_rd_p;
            if (sfu_rvalid || host_rvalid)
                rdata_q <= sram_q;
        end
    end

    // read data is presented straight from the macro in its valid cycle, then held
    assign rdata = (sfu_rvalid || host_rvalid) ? sram_q : rdata_q;

`ifdef PSUM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_sfu_wait  <= '0;
            stat_host_wait <= '0;
        end else begin
            if (sfu_req && !sfu_gnt && stat_sfu_wait != 16'hFFFF)
                stat_sfu_wait <= stat_sfu_wait + 16'd1;
            if (host_req && !host_gnt && stat_host_wait != 16'hFFFF)
                stat_host_wait <= stat_host_wait + 16'd1;
        end
    end
`else
    // no wait-cycle statistics in this build
`endif

endmodule
